mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the RISCV16 core. It sits directly upstream of the register bank and drives its we, regRD_addr and regRD_data.
- Latches retiring instructions from the MEM stage and waits on the data-memory load response.
- Formats load data (word, signed byte, unsigned byte) and selects the writeback source.
- Issues exactly one write per retired instruction and back-pressures MEM while a load is outstanding.

Parameters:
- WORD_W, 16, datapath width.
- RADDR_W, 4, register address width (16 registers, R0 hardwired zero).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; combinational from state.
- in_rd_addr  in  RADDR_W  destination register.
- in_wb_sel  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+2, 3 none.
- in_alu_result  in  WORD_W  ALU result.
- in_pc_plus  in  WORD_W  PC+2 for JAL/JALR link.
- in_load_type  in  2  load width: 0 LW (16-bit), 1 LB, 2 LBU, 3 reserved (treated as LW).
- in_byte_sel  in  1  address bit 0: selects the byte for LB/LBU (0 = [7:0], 1 = [15:8]).
- mem_rvalid  in  1  data-memory read response valid.
- mem_rdata  in  WORD_W  data-memory read word.
- wb_we  out  1  register bank write enable.
- wb_rd_addr  out  RADDR_W  register bank write address.
- wb_rd_data  out  WORD_W  register bank write data.
- load_busy  out  1  high while in WAIT_MEM; goes to the hazard unit.

Behaviour:
- Reset: state EMPTY. wb_we=0, wb_rd_addr=0, wb_rd_data=0, load_busy=0. All latched fields are cleared.
- States and transitions:
  - EMPTY: idle.
  - FULL: commit cycle.
  - WAIT_MEM: load outstanding.
- in_ready = (state != WAIT_MEM). FULL drains unconditionally, so it accepts a new instruction in the same cycle.
- Accept means in_valid && in_ready:
  - wb_sel==MEM: latch fields and go to WAIT_MEM.
  - Any other wb_sel: latch fields, form the result, go to FULL.
- No accept while in FULL: go to EMPTY.
- WAIT_MEM with mem_rvalid=1: format mem_rdata, go to FULL. With mem_rvalid=0: hold, and in_ready stays 0.
- mem_rvalid outside WAIT_MEM is ignored.
- In FULL:
  - wb_we = 1 iff wb_sel != none and rd != 0.
  - wb_rd_addr and wb_rd_data are valid for exactly that one cycle.
  - In every other state wb_we = 0; addr and data hold their last value.
- Result forming:
  - ALU: alu_result.
  - PC+2: pc_plus.
  - MEM:
    - LW: rdata.
    - LB: selected byte sign-extended to 16 bits.
    - LBU: selected byte zero-extended.
- Latency: non-load commits 1 cycle after accept. Load commits 1 cycle after mem_rvalid.
- Back-to-back non-loads sustain one commit per cycle.
- Outputs are registered. The register bank's same-cycle RD forwarding covers the ID read in the commit cycle.
- Reset mid-operation: rst in WAIT_MEM discards the pending load with no write. A mem_rvalid arriving on or after the reset cycle is ignored.
- rd=0 instructions still traverse every state, including WAIT_MEM for loads, but never assert wb_we.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count [15:0], registered, reset to 0.
  - Increments once per FULL cycle, including rd=0 and wb_sel=none instructions.
  - Wraps from 0xFFFF to 0x0000.
- Undefined: the port and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv16_wb_pkg:
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC, WB_NONE.
  - load_type encodings: LD_W, LD_B, LD_BU.
  - state encoding: ST_EMPTY, ST_FULL, ST_WAIT_MEM.
  - WORD_W and RADDR_W defaults.
- Sub-module load_formatter: combinational; inputs rdata, load_type and byte_sel, output the 16-bit result. Instantiated once.

Test Plan:
- ALU op: accept rd=3, wb_sel=ALU, alu=0x1234 -> next cycle wb_we=1, addr=3, data=0x1234; wb_we=0 the following cycle.
- LB sign-extend:
  - Stimulus: accept load rd=5, LB, byte_sel=1; hold mem_rvalid low 3 cycles, then rdata=0x80FF.
  - Response: in_ready=0 and load_busy=1 for 4 cycles, then wb_we=1 with data 0xFF80.
  - Repeat with LBU -> 0x0080.
- Back-to-back: in_valid held 4 cycles with ALU ops rd=1..4 -> 4 consecutive wb_we pulses with matching addr/data and in_ready constant 1.
- R0/none suppression:
  - rd=0 ALU op -> wb_we stays 0.
  - rd=7, wb_sel=none -> wb_we stays 0.
  - JAL-type rd=1, pc_plus=0x0042 -> data 0x0042.
- Reset mid-load: rst asserted in WAIT_MEM, then mem_rvalid=1 on the next cycle -> no wb_we, state EMPTY, in_ready=1.
- WB_RETIRE_CNT_EN: preload counter by 65535 retirements, retire one more -> retire_count=0x0000.

Source files
------------

// File: rtl/riscv16_wb_pkg.sv
// Shared encodings and defaults for the RISCV16 MEM/WB writeback stage.
// Used by mem_wb_stage and load_formatter.
package riscv16_wb_pkg;

    localparam int WORD_W_DEF  = 16;
    localparam int RADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC   = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_W   = 2'd0,
        LD_B   = 2'd1,
        LD_BU  = 2'd2,
        LD_RSV = 2'd3
    } load_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_WAIT_MEM = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Shapes a raw data-memory word into LW / LB / LBU register data.
// The reserved load type falls through to a full-word load.
module load_formatter
    import riscv16_wb_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        load_type,
    input  logic              byte_sel,
    output logic [WORD_W-1:0] result
);

    logic [7:0] byte_v;

    always_comb begin
        byte_v = byte_sel ? rdata[15:8] : rdata[7:0];
        result = rdata;
        unique case (1'b1)
            load_type == LD_B:
                result = {{(WORD_W-8){byte_v[7]}}, byte_v};
            load_type == LD_BU:
                result = {{(WORD_W-8){1'b0}}, byte_v};
            default:
                result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// RISCV16 MEM/WB stage: waits on load data, formats it, one write per retire.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import riscv16_wb_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [1:0]         in_wb_sel,
    input  logic [WORD_W-1:0]  in_alu_result,
    input  logic [WORD_W-1:0]  in_pc_plus,
    input  logic [1:0]         in_load_type,
    input  logic               in_byte_sel,
    input  logic               mem_rvalid,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd_addr,
    output logic [WORD_W-1:0]  wb_rd_data,
    output logic               load_busy
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [15:0]        retire_count
`endif
);

    wb_state_e          state;
    logic [RADDR_W-1:0] rd_q;
    logic [1:0]         lt_q;
    logic               bs_q;
    logic [WORD_W-1:0]  ld_data;
    logic [WORD_W-1:0]  alu_pc;
    logic               accept;
    logic               rd_nz;

    assign in_ready  = (state != ST_WAIT_MEM);
    assign load_busy = (state == ST_WAIT_MEM);
    assign accept    = in_valid && in_ready;
    assign rd_nz     = (in_rd_addr != '0);
    assign alu_pc    = (in_wb_sel == WB_PC) ? in_pc_plus : in_alu_result;

    load_formatter #(.WORD_W(WORD_W)) u_fmt (
        .rdata     (mem_rdata),
        .load_type (lt_q),
        .byte_sel  (bs_q),
        .result    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            wb_we      <= 1'b0;
            wb_rd_addr <= '0;
            wb_rd_data <= '0;
            rd_q       <= '0;
            lt_q       <= LD_W;
            bs_q       <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            if (state == ST_WAIT_MEM) begin
                if (mem_rvalid) begin
                    state      <= ST_FULL;
                    wb_we      <= (rd_q != '0);
                    wb_rd_addr <= rd_q;
                    wb_rd_data <= ld_data;
                end
            end else if (accept) begin
                rd_q <= in_rd_addr;
                lt_q <= in_load_type;
                bs_q <= in_byte_sel;
                if (in_wb_sel == WB_MEM) begin
                    state <= ST_WAIT_MEM;
                end else begin
                    state      <= ST_FULL;
                    wb_we      <= rd_nz && (in_wb_sel != WB_NONE);
                    wb_rd_addr <= in_rd_addr;
                    wb_rd_data <= alu_pc;
                end
            end else begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Counts every commit cycle, including suppressed writes.
    always_ff @(posedge clk) begin
        if (rst)
            retire_count <= '0;
        else if (state == ST_FULL)
            retire_count <= retire_count + 16'd1;
    end
`endif

endmodule
